// File: rtl/vcortex_pwm_gen.sv
// Multi-channel PWM generator: scans the PWM RAM into staging once per period, loads active duties at wrap.
// Optional build macro VCORTEX_PWM_POL_INV_EN selects active-low outputs.
module vcortex_pwm_gen #(
   parameter int P_NUM_CH       = 16,
   parameter int P_RAM_ADDR_W   = 4,
   parameter int P_RAM_DATA_W   = 16,
   parameter int P_PWM_W        = 8,
   parameter int P_PRESCALE     = 4,
   parameter int P_RAM_RD_DELAY = 1
) (
   input  logic                    clk_ir,
   input  logic                    rst_il,
   input  logic                    pwm_gen_en_ih,
   output logic [P_RAM_ADDR_W-1:0] pwm_ram_rd_addr_od,
   input  logic [P_RAM_DATA_W-1:0] pwm_ram_rd_data_id,
   output logic [P_NUM_CH-1:0]     pwm_oh,
   output logic                    pwm_period_start_oh
);

   localparam int PS_W = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
   localparam int DLY  = P_RAM_RD_DELAY;
   localparam logic [P_RAM_ADDR_W-1:0] LAST_CH = P_RAM_ADDR_W'(P_NUM_CH - 1);
`ifdef VCORTEX_PWM_POL_INV_EN
   localparam logic ACT = 1'b0;
`else
   localparam logic ACT = 1'b1;
`endif

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                          state_q, state_d;
   logic [PS_W-1:0]                 presc_q;
   logic [P_PWM_W-1:0]              cnt_q;
   logic [P_RAM_ADDR_W-1:0]         fcnt_q;
   logic                            fetch_q;
   logic                            fill_done_q;
   logic [DLY-1:0]                  vld_pipe;
   logic [DLY-1:0][P_RAM_ADDR_W-1:0] ch_pipe;
   logic [P_NUM_CH-1:0][P_PWM_W:0]  staging_q, active_q;
   logic [P_NUM_CH-1:0]             hit;
   logic                            tick, wrap, load, start_fetch, run;

   assign tick        = (presc_q == PS_W'(P_PRESCALE - 1));
   assign wrap        = tick && (cnt_q == {P_PWM_W{1'b1}});
   assign run         = (state_q == RUN) && pwm_gen_en_ih;
   assign start_fetch = ((state_q == IDLE) && pwm_gen_en_ih) || load;

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE:  if (pwm_gen_en_ih) state_d = PRIME;
         PRIME: begin
            if (!pwm_gen_en_ih) state_d = IDLE;
            else if (fill_done_q) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (!pwm_gen_en_ih) state_d = IDLE;
            else if (wrap)      load    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Fetch sequencer: address issue plus a valid/channel shift register matching the RAM read latency.
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         pwm_ram_rd_addr_od <= '0;
         fcnt_q             <= '0;
         fetch_q            <= 1'b0;
         fill_done_q        <= 1'b0;
         vld_pipe           <= '0;
         ch_pipe            <= '0;
         staging_q          <= '0;
      end else if (!pwm_gen_en_ih) begin
         fcnt_q      <= '0;
         fetch_q     <= 1'b0;
         fill_done_q <= 1'b0;
         vld_pipe    <= '0;
      end else begin
         vld_pipe[0] <= fetch_q;
         ch_pipe[0]  <= fcnt_q;
         for (int i = 1; i < DLY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            ch_pipe[i]  <= ch_pipe[i-1];
         end
         if (fetch_q) begin
            pwm_ram_rd_addr_od <= fcnt_q;
            fcnt_q             <= fcnt_q + P_RAM_ADDR_W'(1);
            if (fcnt_q == LAST_CH) fetch_q <= 1'b0;
         end
         if (start_fetch) begin
            fetch_q <= 1'b1;
            fcnt_q  <= '0;
         end
         if (vld_pipe[DLY-1])
            staging_q[ch_pipe[DLY-1]] <= pwm_ram_rd_data_id[P_PWM_W:0];
         fill_done_q <= vld_pipe[DLY-1] && (ch_pipe[DLY-1] == LAST_CH);
      end
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         presc_q             <= '0;
         cnt_q               <= '0;
         active_q            <= '0;
         pwm_period_start_oh <= 1'b0;
      end else begin
         pwm_period_start_oh <= load;
         if (load) begin
            active_q <= staging_q;
            presc_q  <= '0;
            cnt_q    <= '0;
         end else if (run) begin
            presc_q <= tick ? '0 : presc_q + PS_W'(1);
            if (tick) cnt_q <= cnt_q + P_PWM_W'(1);
         end else begin
            presc_q <= '0;
            cnt_q   <= '0;
         end
      end
   end

   for (genvar ch = 0; ch < P_NUM_CH; ch++) begin : g_ch
      assign hit[ch] = active_q[ch][P_PWM_W] | (cnt_q < active_q[ch][P_PWM_W-1:0]);
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il)  pwm_oh <= {P_NUM_CH{~ACT}};
      else if (run) pwm_oh <= hit ^ {P_NUM_CH{~ACT}};
      else          pwm_oh <= {P_NUM_CH{~ACT}};
   end

   if (P_RAM_DATA_W > P_PWM_W + 1) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^pwm_ram_rd_data_id[P_RAM_DATA_W-1:P_PWM_W+1];
   end

endmodule

// File: doc/vcortex_pwm_gen.md
# vcortex_pwm_gen

Multi-channel PWM generator for the VCORTEX LED outputs, downstream of the VCORTEX local-bus decoder. It scans the PWM RAM read port once per PWM period into staging registers. At each period boundary it transfers the staged duty values into active registers, so duty updates are glitch-free. It drives one registered PWM output per channel, gated by the global PWM enable bit held in the VCORTEX register block.

## Interface
- P_NUM_CH, 16, number of channels; equals the PWM RAM depth (2^P_RAM_ADDR_W).
- P_RAM_ADDR_W, 4, PWM RAM address width.
- P_RAM_DATA_W, 16, PWM RAM data width.
- P_PWM_W, 8, duty and period-counter width.
- P_PRESCALE, 4, clocks per PWM tick (≥1).
- P_RAM_RD_DELAY, 1, clocks from address to valid read data on the RAM read port.

Ports:
- clk_ir  in  1  clock.
- rst_il  in  1  reset, asynchronous, active-low.
- pwm_gen_en_ih  in  1  1 -> PWM running; 0 -> outputs idle, counters cleared.
- pwm_ram_rd_addr_od  out  P_RAM_ADDR_W  PWM RAM read address.
- pwm_ram_rd_data_id  in  P_RAM_DATA_W  PWM RAM read data.
- pwm_oh  out  P_NUM_CH  per-channel PWM output, registered.
- pwm_period_start_oh  out  1  one-clock pulse when the active duties load (period start).

## Operation
- RAM word format:
  - Bits [P_PWM_W-1:0] hold the duty D.
  - Bit [P_PWM_W] is FULL; FULL=1 forces the channel on for the whole period.
  - Remaining bits are ignored.
- FSM states: IDLE, PRIME, RUN.
- IDLE:
  - Outputs are all at the inactive level, prescaler and period counter are 0, and the fetch counter is 0.
  - Move to PRIME when pwm_gen_en_ih=1.
- PRIME (initial fill):
  - Issue addresses 0..P_NUM_CH-1 on consecutive clocks.
  - Capture each word into staging[ch] P_RAM_RD_DELAY clocks after its address.
  - After the last capture: load staging into active, pulse pwm_period_start_oh, set cnt=0, and go to RUN.
- RUN:
  - The prescaler counts 0..P_PRESCALE-1; tick is asserted when it equals P_PRESCALE-1.
  - The period counter cnt (P_PWM_W bits) increments on each tick and wraps from 2^P_PWM_W-1 to 0.
  - Concurrent fetch sequencer: starts on the first clock after each active load and re-reads all channels into staging, same addressing and latency as PRIME. When idle, the address is held at its last value.
  - Period wrap (tick with cnt=max): load staging into active, pulse pwm_period_start_oh.
  - Channel output: active-level when FULL=1 or cnt < D. D=0 with FULL=0 gives always inactive. D=2^P_PWM_W-1 gives active for 255 of 256 ticks.
- pwm_gen_en_ih=0 in any state:
  - Return to IDLE on the next clock and drive outputs inactive on that same clock.
  - Abandon any fetch in progress; staging and active contents are retained but not used.
  - Re-enabling always goes through PRIME.
- Build requirement: 2^P_PWM_W·P_PRESCALE > P_NUM_CH + P_RAM_RD_DELAY + 2, so each fetch completes before its period wraps. With the defaults this is 1024 > 19.

## Timing
- Reset values:
  - pwm_oh = inactive level (all 0, or all 1 with inversion).
  - pwm_period_start_oh = 0.
  - pwm_ram_rd_addr_od = 0.
  - State IDLE; all counters, staging and active registers 0.
- Enable at clock E (first edge sampling 1):
  - Address 0 is driven at E+1.
  - The last capture occurs at E+P_NUM_CH+P_RAM_RD_DELAY.
  - The load and pulse occur at E+P_NUM_CH+P_RAM_RD_DELAY+1; with the defaults, E+18.
  - pwm_oh reflects the new duties on the clock after the load.
- Period length is 2^P_PWM_W·P_PRESCALE clocks; pwm_period_start_oh pulses are exactly that far apart.
- The output is a registered comparison: channel ch is active for D·P_PRESCALE clocks per period.
- A RAM write landing after the fetch has read that channel takes effect one period later. A write landing before the fetch reaches that channel takes effect at the next wrap.

## Configuration
- Macro VCORTEX_PWM_POL_INV_EN:
  - Defined: the active level is 0 and the inactive level is 1. This applies to pwm_oh, including the reset value and IDLE; it suits active-low LED drivers.
  - Undefined: the active level is 1 and the inactive level is 0.
- No other behaviour changes with the macro.

## Test plan
- Reset, then enable with RAM ch0=0x0040, ch1=0x0000, ch2=0x0100, ch3=0x00FF:
  - First pulse at E+18.
  - ch0 high 256 clocks per 1024-clock period.
  - ch1 always low.
  - ch2 always high.
  - ch3 high 1020 clocks.
- Mid-period RAM change:
  - Write ch0=0x0080 before the fetch reaches ch0: the new duty appears at the next pwm_period_start_oh.
  - Write after the fetch passed ch0: the new duty appears one period later. No truncated or extra pulse in either case.
- Disable mid-period, then re-enable:
  - pwm_oh goes to 0 one clock after the disable.
  - On re-enable, PRIME runs again and the first pulse follows after 18 clocks.
- Address sweep:
  - pwm_ram_rd_addr_od walks 0..15 on consecutive clocks once per period.
  - pwm_period_start_oh pulses are exactly 1024 clocks apart over 4 periods.
- Assert rst_il low during PRIME:
  - All outputs return to reset values immediately.
  - After reset release with enable held at 1, a full PRIME restarts from address 0.
- Build with VCORTEX_PWM_POL_INV_EN defined and repeat the first scenario:
  - Waveforms are the exact complement.
  - pwm_oh = 0xFFFF in reset and IDLE.
